// File: rtl/femto_mem_bridge.sv
// FemtoRV32 bus bridge: decodes core accesses to a synchronous word RAM or an IO page.
// Optional macro FEMTO_BRIDGE_TIMEOUT_EN adds an IO watchdog and a sticky bus_err output.
module femto_mem_bridge #(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned IO_BIT     = 22,
    parameter int unsigned RAM_WAIT   = 0,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wmask,
    input  logic                  mem_rstrb,
    output logic [31:0]           mem_rdata,
    output logic                  mem_rbusy,
    output logic                  mem_wbusy,
    output logic [ADDR_WIDTH-3:0] ram_addr,
    output logic [31:0]           ram_wdata,
    output logic [3:0]            ram_wmask,
    output logic                  ram_en,
    input  logic [31:0]           ram_rdata,
    output logic [7:0]            io_addr,
    output logic [31:0]           io_wdata,
    output logic [3:0]            io_wstrb,
    output logic                  io_rstrb,
    input  logic [31:0]           io_rdata,
`ifdef FEMTO_BRIDGE_TIMEOUT_EN
    output logic                  bus_err,
`endif
    input  logic                  io_ready
);

    typedef enum logic [2:0] {
        StIdle, StRamAcc, StRamWait, StRamCap, StIoAcc, StIoWait
    } state_e;

    localparam logic [3:0] WaitLast = 4'(RAM_WAIT - 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic [3:0]              wmask_q;
    logic [31:0]             rdata_q, rdata_d;
    logic                    rdata_load;
    logic                    rbusy_q, wbusy_q;
    logic [3:0]              wait_cnt_q;
    logic                    accept, is_wr, wr_d, busy_d, io_phase, io_tmo;
    logic                    unused_addr;

    assign unused_addr = ^mem_addr[31:ADDR_WIDTH];

    assign accept   = (state_q == StIdle) && (mem_rstrb || (mem_wmask != 4'd0));
    assign is_wr    = (wmask_q != 4'd0);
    // A write request wins over a simultaneous read strobe.
    assign wr_d     = accept ? (mem_wmask != 4'd0) : is_wr;
    assign busy_d   = (state_d != StIdle);
    assign io_phase = (state_q == StIoAcc) || (state_q == StIoWait);

`ifdef FEMTO_BRIDGE_TIMEOUT_EN
    localparam int unsigned TmoW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

    logic [TmoW-1:0] tmo_cnt_q;
    logic            bus_err_q;

    assign io_tmo  = (state_q == StIoWait) && !io_ready && (tmo_cnt_q == TmoLast);
    assign bus_err = bus_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= (state_q == StIoWait) ? tmo_cnt_q + 1'b1 : '0;
            if (io_tmo) bus_err_q <= 1'b1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT != 0);
    assign io_tmo     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = mem_addr[IO_BIT] ? StIoAcc : StRamAcc;
            end
            StRamAcc: begin
                if (RAM_WAIT > 0) state_d = StRamWait;
                else              state_d = is_wr ? StIdle : StRamCap;
            end
            StRamWait: begin
                if (wait_cnt_q == WaitLast) state_d = is_wr ? StIdle : StRamCap;
            end
            StRamCap: state_d = StIdle;
            StIoAcc, StIoWait: begin
                state_d = (io_ready || io_tmo) ? StIdle : StIoWait;
            end
            default: state_d = StIdle;
        endcase
    end

    // Read data only moves on read completion; timed-out IO reads return a marker word.
    always_comb begin
        rdata_load = 1'b0;
        rdata_d    = rdata_q;
        if (state_q == StRamCap) begin
            rdata_load = 1'b1;
            rdata_d    = ram_rdata;
        end else if (io_phase && !is_wr && io_ready) begin
            rdata_load = 1'b1;
            rdata_d    = io_rdata;
        end else if (io_phase && !is_wr && io_tmo) begin
            rdata_load = 1'b1;
            rdata_d    = 32'hDEADBEEF;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            rdata_q    <= '0;
            rbusy_q    <= 1'b0;
            wbusy_q    <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= mem_addr[ADDR_WIDTH-1:0];
                wdata_q <= mem_wdata;
                wmask_q <= mem_wmask;
            end
            rbusy_q    <= busy_d && !wr_d;
            wbusy_q    <= busy_d && wr_d;
            wait_cnt_q <= (state_q == StRamWait) ? wait_cnt_q + 4'd1 : 4'd0;
            if (rdata_load) rdata_q <= rdata_d;
        end
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_wmask = 4'd0;
        io_rstrb  = 1'b0;
        io_wstrb  = 4'd0;
        if (state_q == StRamAcc) begin
            ram_en    = 1'b1;
            ram_wmask = wmask_q;
        end
        if (state_q == StIoAcc) begin
            io_rstrb = !is_wr;
            io_wstrb = wmask_q;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_rbusy = rbusy_q;
    assign mem_wbusy = wbusy_q;
    assign ram_addr  = addr_q[ADDR_WIDTH-1:2];
    assign ram_wdata = wdata_q;
    assign io_addr   = addr_q[7:0];
    assign io_wdata  = wdata_q;

endmodule
